// File: rtl/nios_mul_seq.sv
// nios_mul_seq: multi-cycle Nios II MUL / MULXUU / MULXSS / MULXSU sequencer.
// Operands are reduced to magnitudes, and four 16x16 partial products are
// issued through one registered unsigned multiplier and summed into a 64-bit
// accumulator. The sign is restored at the end.
// Optional build macro: NIOS_MUL_SEQ_SKIP_HIGH_PP_EN skips the AH*BH partial
// for MUL. That partial only lands in bits 63:32, so the low word is unaffected.
module nios_mul_seq #(
  parameter bit FLUSH_CLEARS_RESULT = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [1:0]  start_op,
  input  logic [31:0] start_src1,
  input  logic [31:0] start_src2,
  input  logic        flush,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [31:0] result_data,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ACC, S_FIX, S_DONE} state_t;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXSS = 2'b10;

  state_t      r_state;
  logic [1:0]  r_op;
  logic        r_neg;
  logic [31:0] r_mag_a;
  logic [31:0] r_mag_b;
  logic [63:0] r_acc;
  logic [1:0]  r_k;
  logic [31:0] r_prod;
  logic        r_pp_valid;
  logic [1:0]  r_pp_k;
  logic        r_start_ready;
  logic        r_result_valid;
  logic [31:0] r_result_data;
  logic        r_busy;

  logic        w_accept;
  logic        w_flush;
  logic        w_sign_a;
  logic        w_sign_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_op_a;
  logic [31:0] w_op_b;
  logic [63:0] w_pp_shifted;
  logic [63:0] w_acc_sum;
  logic [63:0] w_acc_fixed;
  logic [1:0]  w_last_k;

  // Operand conditioning, partial-product selection and accumulator arithmetic.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_pp_shifted = 64'd0;
    w_accept     = start_valid & r_start_ready;
    w_flush      = flush & (r_state != S_IDLE);
    // A is signed for MULXSS/MULXSU, B only for MULXSS.
    w_sign_a     = start_op[1] & start_src1[31];
    w_sign_b     = (start_op == OP_MULXSS) & start_src2[31];
    // Two's-complement magnitude; 0x80000000 maps onto itself as an unsigned value.
    w_mag_a      = w_sign_a ? (~start_src1 + 32'd1) : start_src1;
    w_mag_b      = w_sign_b ? (~start_src2 + 32'd1) : start_src2;
    // k bit 0 picks AH, k bit 1 picks BH: k0=AL*BL, k1=AH*BL, k2=AL*BH, k3=AH*BH.
    w_op_a       = {16'd0, (r_k[0] ? r_mag_a[31:16] : r_mag_a[15:0])};
    w_op_b       = {16'd0, (r_k[1] ? r_mag_b[31:16] : r_mag_b[15:0])};
    case (r_pp_k)
      2'd0:    w_pp_shifted = {32'd0, r_prod};
      2'd3:    w_pp_shifted = {r_prod, 32'd0};
      default: w_pp_shifted = {16'd0, r_prod, 16'd0};
    endcase
    w_acc_sum    = r_acc + (r_pp_valid ? w_pp_shifted : 64'd0);
    w_acc_fixed  = r_neg ? (~r_acc + 64'd1) : r_acc;
`ifdef NIOS_MUL_SEQ_SKIP_HIGH_PP_EN
    w_last_k     = (r_op == OP_MUL) ? 2'd2 : 2'd3;
`else
    w_last_k     = 2'd3;
`endif
  end

  // Registered 16x16 multiplier; tags each product with the k that produced it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prod     <= 32'd0;
      r_pp_valid <= 1'b0;
      r_pp_k     <= 2'd0;
    end else if (w_flush) begin
      r_prod     <= 32'd0;
      r_pp_valid <= 1'b0;
      r_pp_k     <= 2'd0;
    end else if (r_state == S_ISSUE) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_prod     <= w_op_a * w_op_b;
      r_pp_valid <= 1'b1;
      r_pp_k     <= r_k;
    end else begin
      r_pp_valid <= 1'b0;
    end
  end

  // Sequencer FSM with accumulator, sign fix-up and registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_op           <= OP_MUL;
      r_neg          <= 1'b0;
      r_mag_a        <= 32'd0;
      r_mag_b        <= 32'd0;
      r_acc          <= 64'd0;
      r_k            <= 2'd0;
      r_start_ready  <= 1'b1;
      r_result_valid <= 1'b0;
      r_result_data  <= 32'd0;
      r_busy         <= 1'b0;
    end else if (w_flush) begin
      r_state        <= S_IDLE;
      r_acc          <= 64'd0;
      r_k            <= 2'd0;
      r_start_ready  <= 1'b1;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
      if (FLUSH_CLEARS_RESULT) r_result_data <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op          <= start_op;
            r_neg         <= w_sign_a ^ w_sign_b;
            r_mag_a       <= w_mag_a;
            r_mag_b       <= w_mag_b;
            r_acc         <= 64'd0;
            r_k           <= 2'd0;
            r_state       <= S_ISSUE;
            r_start_ready <= 1'b0;
            r_busy        <= 1'b1;
          end
        end
        S_ISSUE: begin
          // Each edge adds the product issued one cycle earlier (none on k0).
          r_acc <= w_acc_sum;
          if (r_k == w_last_k) begin
            r_k     <= 2'd0;
            r_state <= S_ACC;
          end else begin
            r_k <= r_k + 2'd1;
          end
        end
        S_ACC: begin
          r_acc   <= w_acc_sum;
          r_state <= S_FIX;
        end
        S_FIX: begin
          r_acc          <= w_acc_fixed;
          r_result_data  <= (r_op == OP_MUL) ? w_acc_fixed[31:0] : w_acc_fixed[63:32];
          r_result_valid <= 1'b1;
          r_state        <= S_DONE;
        end
        S_DONE: begin
          if (result_ready) begin
            r_result_valid <= 1'b0;
            r_start_ready  <= 1'b1;
            r_busy         <= 1'b0;
            r_state        <= S_IDLE;
          end
        end
        default: begin
          r_state        <= S_IDLE;
          r_start_ready  <= 1'b1;
          r_result_valid <= 1'b0;
          r_busy         <= 1'b0;
        end
      endcase
    end
  end

  assign start_ready  = r_start_ready;
  assign result_valid = r_result_valid;
  assign result_data  = r_result_data;
  assign busy         = r_busy;

endmodule

// File: tb/tb_nios_mul_seq.sv
// tb_nios_mul_seq: directed self-checking bench for nios_mul_seq.
// Expected results are hand-computed products. The MUL latency follows
// NIOS_MUL_SEQ_SKIP_HIGH_PP_EN.
module tb_nios_mul_seq;

`ifdef NIOS_MUL_SEQ_SKIP_HIGH_PP_EN
  localparam int LAT_MUL = 5;
`else
  localparam int LAT_MUL = 6;
`endif
  localparam int LAT_MULX = 6;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_valid;
  logic        start_ready;
  logic [1:0]  start_op;
  logic [31:0] start_src1;
  logic [31:0] start_src2;
  logic        flush;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result_data;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  nios_mul_seq dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .start_op     (start_op),
    .start_src1   (start_src1),
    .start_src2   (start_src2),
    .flush        (flush),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_data  (result_data),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one request for a single edge (E0); returns #1 after E0.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start_op    = op;
    start_src1  = a;
    start_src2  = b;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
  endtask

  // Waits (bounded) for result_valid; returns the number of edges after E0.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (result_valid === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_data, input int exp_lat);
    int lat;
    check({tag, " start_ready"}, start_ready, 1);
    issue(op, a, b);
    check({tag, " busy"}, busy, 1);
    wait_valid(lat);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " data"}, result_data, exp_data);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    check({tag, " valid_drop"}, result_valid, 0);
    check({tag, " ready_back"}, start_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset_n      = 1'b0;
    start_valid  = 1'b0;
    start_op     = 2'b00;
    start_src1   = 32'd0;
    start_src2   = 32'd0;
    flush        = 1'b0;
    result_ready = 1'b0;
    #12;
    check("rst start_ready", start_ready, 1);
    check("rst result_valid", result_valid, 0);
    check("rst result_data", result_data, 0);
    check("rst busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Main function across all four ops.
    run_op("mulxuu ff*ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_MULX);
    run_op("mul ff*ff",    2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, LAT_MUL);
    run_op("mulxss min*min", 2'b10, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_MULX);
    run_op("mulxsu -1*ff", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_MULX);
    run_op("mulxss -1*2",  2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, LAT_MULX);
    run_op("mulxsu min*2^31", 2'b11, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, LAT_MULX);
    run_op("mul -3*5",     2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, LAT_MUL);
    run_op("mul big",      2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 32'h242D_2080, LAT_MUL);
    run_op("mulxuu big",   2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, LAT_MULX);

    // Backpressure: result held for 10 cycles, stray start pulse ignored.
    issue(2'b01, 32'h0001_0000, 32'h0001_0000);
    wait_valid(lat);
    check("bp latency", lat, LAT_MULX);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        start_op    = 2'b00;
        start_src1  = 32'd3;
        start_src2  = 32'd5;
        start_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      check("bp hold data", result_data, 32'h0000_0001);
      check("bp hold valid", result_valid, 1);
      check("bp start_ready low", start_ready, 0);
    end
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    check("bp valid_drop", result_valid, 0);
    check("bp ready_back", start_ready, 1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("bp ignored start", busy, 0);
    end

    // Flush during the ISSUE k=2 cycle.
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush busy", busy, 0);
    check("flush start_ready", start_ready, 1);
    check("flush result_valid", result_valid, 0);
    check("flush result_data", result_data, 0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("flush no result", result_valid, 0);
    end
    run_op("post-flush mul 3*5", 2'b00, 32'd3, 32'd5, 32'h0000_000F, LAT_MUL);

    // Asynchronous reset in the middle of ISSUE.
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst result_valid", result_valid, 0);
    check("arst start_ready", start_ready, 1);
    check("arst busy", busy, 0);
    check("arst result_data", result_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("post-reset mul 3*5", 2'b00, 32'd3, 32'd5, 32'h0000_000F, LAT_MUL);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
